// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the PC sequencer (master) and instruction memory (slave).
// imem_rdata is only meaningful in a cycle where imem_ack is high.
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [31:0]           imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program counter and next-PC selection: fetches over a req/ack handshake and holds the
// word until the core retires it. Define PC_ALIGN_CHECK_EN to trap misaligned jr targets.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0040_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 32'h8000_0180
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  advance,
  input  logic [1:0]            pc_sel,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_off_sl2,
  input  logic [27:0]           jump_idx_sl2,
  input  logic [ADDR_WIDTH-1:0] jr_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  misalign_err
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]           instr_reg, instr_next;
  logic                  instr_valid_reg, instr_valid_next;

  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pc_load;
  logic                  retire;

  assign pc_plus4      = pc_reg + ADDR_WIDTH'(4);
  assign branch_target = pc_plus4 + branch_off_sl2;
  assign retire        = (state_reg == S_ISSUE) && instr_valid_reg && advance;

  // Jump keeps the region bits of the delay-slot address, not of the jump itself.
  always_comb begin
    next_pc = jr_target;
    case (pc_sel)
      SEL_SEQ:    next_pc = pc_plus4;
      SEL_BRANCH: next_pc = branch_taken ? branch_target : pc_plus4;
      SEL_JUMP:   next_pc = {pc_plus4[ADDR_WIDTH-1:ADDR_WIDTH-4], jump_idx_sl2};
      default:    next_pc = jr_target;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_reg;
  logic target_misaligned;

  assign target_misaligned = |next_pc[1:0];
  assign pc_load           = target_misaligned ? TRAP_VECTOR : next_pc;
  assign misalign_err      = misalign_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
    end else if (retire && target_misaligned) begin
      misalign_reg <= 1'b1;
    end
  end
`else
  logic unused_align_cfg;

  assign pc_load          = {next_pc[ADDR_WIDTH-1:2], 2'b00};
  assign misalign_err     = 1'b0;
  assign unused_align_cfg = ^{TRAP_VECTOR, next_pc[1:0]};
`endif

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    case (state_reg)
      S_BOOT: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_next       = imem.imem_rdata;
          instr_valid_next = 1'b1;
          state_next       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (retire) begin
          pc_next          = pc_load;
          instr_valid_next = 1'b0;
          state_next       = S_FETCH;
        end
      end
      default: begin
        state_next       = S_BOOT;
        instr_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_BOOT;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  // Request is decoded from state so an asynchronous reset drops it without waiting for a clock.
  assign imem.imem_req  = (state_reg == S_FETCH);
  assign imem.imem_addr = pc_reg;

  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the bench plays instruction memory and the retiring core.
// Expectations follow the PC_ALIGN_CHECK_EN setting of the build.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0040_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h8000_0180;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        advance;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [31:0] branch_off_sl2;
  logic [27:0] jump_idx_sl2;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  pc_sequencer_if #(.ADDR_WIDTH(32)) imem_bus ();

  pc_sequencer #(
    .ADDR_WIDTH (32),
    .RESET_PC   (RESET_PC),
    .TRAP_VECTOR(TRAP_VECTOR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .advance       (advance),
    .pc_sel        (pc_sel),
    .branch_taken  (branch_taken),
    .branch_off_sl2(branch_off_sl2),
    .jump_idx_sl2  (jump_idx_sl2),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // Bounded wait (in negedges) for a fetch request; a timeout counts as a failed comparison.
  task automatic wait_req();
    int n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL wait_req: imem_req=%b after %0d cycles, required 1", imem_bus.imem_req, n);
    end
  endtask

  // Called at a negedge with imem_req high; acks after 'waits' stall cycles.
  task automatic fetch(input logic [31:0] word, input int waits);
    repeat (waits) @(negedge clk);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    $display("txn fetch addr=%08h word=%08h waits=%0d", imem_bus.imem_addr, word, waits);
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
  endtask

  // Called at a negedge in the issue state; returns at the negedge after the advance edge.
  task automatic retire(input logic [1:0] sel, input logic taken, input logic [31:0] off,
                        input logic [27:0] idx, input logic [31:0] jr);
    pc_sel         = sel;
    branch_taken   = taken;
    branch_off_sl2 = off;
    jump_idx_sl2   = idx;
    jr_target      = jr;
    advance        = 1'b1;
    $display("txn retire pc=%08h sel=%b taken=%b off=%08h idx=%07h jr=%08h",
             pc, sel, taken, off, idx, jr);
    @(negedge clk);
    advance = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    wait_req();
    fetch(NOP_WORD, 0);
    retire(2'b11, 1'b0, 32'h0, 28'h0, target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req);
    end
    checks++;
    if (pc !== RESET_PC) begin
      failures++; $display("FAIL reset_pc: got %08h want %08h", pc, RESET_PC);
    end
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_instr: got instr=%08h valid=%b err=%b want 00000000/0/0",
               instr, instr_valid, misalign_err);
    end
    rst_n = 1'b1;
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL boot_req: got %b want 0", imem_bus.imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL first_fetch: got req=%b addr=%08h want 1/%08h",
               imem_bus.imem_req, imem_bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait_fetch();
    wait_req();
    fetch(32'h2008_0005, 0);
    checks++;
    if (instr !== 32'h2008_0005 || instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL zero_wait: got instr=%08h valid=%b req=%b want 20080005/1/0",
               instr, instr_valid, imem_bus.imem_req);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc !== RESET_PC) begin
      failures++;
      $display("FAIL issue_hold: got valid=%b pc=%08h want 1/%08h", instr_valid, pc, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    retire(2'b00, 1'b0, 32'h0, 28'h0, 32'h0);
    checks++;
    if (pc !== 32'h0040_0004 || imem_bus.imem_req !== 1'b1 ||
        imem_bus.imem_addr !== 32'h0040_0004 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq: got pc=%08h req=%b addr=%08h valid=%b want 00400004/1/00400004/0",
               pc, imem_bus.imem_req, imem_bus.imem_addr, instr_valid);
    end
  endtask

  task automatic test_advance_in_fetch();
    pc_sel    = 2'b11;
    jr_target = 32'h1234_0000;
    advance   = 1'b1;
    repeat (2) @(negedge clk);
    advance = 1'b0;
    checks++;
    if (pc !== 32'h0040_0004 || imem_bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL adv_in_fetch: got pc=%08h req=%b want 00400004/1", pc, imem_bus.imem_req);
    end
    fetch(32'h8C08_0000, 2);
    checks++;
    if (instr !== 32'h8C08_0000 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_fetch: got instr=%08h valid=%b want 8c080000/1", instr, instr_valid);
    end
  endtask

  task automatic test_branch();
    retire(2'b00, 1'b0, 32'h0, 28'h0, 32'h0);
    goto_pc(32'h0040_0010);
    wait_req();
    fetch(32'h1000_FFFC, 0);
    retire(2'b01, 1'b1, 32'hFFFF_FFF0, 28'h0, 32'h0);
    checks++;
    if (pc !== 32'h0040_0004) begin
      failures++; $display("FAIL branch_taken: got %08h want 00400004", pc);
    end
    goto_pc(32'h0040_0010);
    wait_req();
    fetch(32'h1000_FFFC, 0);
    checks++;
    if (pc_plus4 !== 32'h0040_0014) begin
      failures++; $display("FAIL pc_plus4: got %08h want 00400014", pc_plus4);
    end
    retire(2'b01, 1'b0, 32'hFFFF_FFF0, 28'h0, 32'h0);
    checks++;
    if (pc !== 32'h0040_0014) begin
      failures++; $display("FAIL branch_not_taken: got %08h want 00400014", pc);
    end
  endtask

  task automatic test_jump_region();
    goto_pc(32'h0FFF_FFFC);
    wait_req();
    fetch(32'h0800_0010, 0);
    checks++;
    if (pc_plus4 !== 32'h1000_0000) begin
      failures++; $display("FAIL region_plus4: got %08h want 10000000", pc_plus4);
    end
    retire(2'b10, 1'b0, 32'h0, 28'h000_0040, 32'h0);
    checks++;
    if (pc !== 32'h1000_0040) begin
      failures++; $display("FAIL jump_region: got %08h want 10000040", pc);
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    wait_req();
    fetch(NOP_WORD, 0);
    checks++;
    if (pc_plus4 !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap_plus4: got %08h want 00000000", pc_plus4);
    end
    retire(2'b00, 1'b0, 32'h0, 28'h0, 32'h0);
    checks++;
    if (pc !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap_seq: got %08h want 00000000", pc);
    end
    wait_req();
    fetch(NOP_WORD, 0);
    retire(2'b01, 1'b1, 32'hFFFF_FFF8, 28'h0, 32'h0);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_branch_back: got %08h want fffffffc", pc);
    end
  endtask

  task automatic test_jr_misaligned();
    logic [31:0] want_pc;
    logic        want_err;
`ifdef PC_ALIGN_CHECK_EN
    want_pc  = TRAP_VECTOR;
    want_err = 1'b1;
`else
    want_pc  = 32'h0040_0100;
    want_err = 1'b0;
`endif
    wait_req();
    fetch(32'h0100_0008, 0);
    retire(2'b11, 1'b0, 32'h0, 28'h0, 32'h0040_0102);
    checks++;
    if (pc !== want_pc || imem_bus.imem_addr !== want_pc) begin
      failures++;
      $display("FAIL jr_misaligned_pc: got pc=%08h addr=%08h want %08h",
               pc, imem_bus.imem_addr, want_pc);
    end
    checks++;
    if (misalign_err !== want_err) begin
      failures++; $display("FAIL jr_misaligned_err: got %b want %b", misalign_err, want_err);
    end
    wait_req();
    fetch(NOP_WORD, 0);
    retire(2'b00, 1'b0, 32'h0, 28'h0, 32'h0);
    checks++;
    if (misalign_err !== want_err || pc !== want_pc + 32'd4) begin
      failures++;
      $display("FAIL err_sticky: got err=%b pc=%08h want %b/%08h",
               misalign_err, pc, want_err, want_pc + 32'd4);
    end
  endtask

  task automatic test_reset_mid_fetch();
    wait_req();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0 || pc !== RESET_PC || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got req=%b pc=%08h err=%b want 0/%08h/0",
               imem_bus.imem_req, pc, misalign_err, RESET_PC);
    end
    @(negedge clk);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_bus.imem_req !== 1'b1 ||
        imem_bus.imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL late_ack: got valid=%b instr=%08h req=%b addr=%08h want 0/00000000/1/%08h",
               instr_valid, instr, imem_bus.imem_req, imem_bus.imem_addr, RESET_PC);
    end
    imem_bus.imem_ack = 1'b0;
    fetch(32'h1111_2222, 0);
    checks++;
    if (instr !== 32'h1111_2222 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL refetch: got instr=%08h valid=%b want 11112222/1", instr, instr_valid);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    advance             = 1'b0;
    pc_sel              = 2'b00;
    branch_taken        = 1'b0;
    branch_off_sl2      = 32'h0;
    jump_idx_sl2        = 28'h0;
    jr_target           = 32'h0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_zero_wait_fetch();
    test_sequential();
    test_advance_in_fetch();
    test_branch();
    test_jump_region();
    test_wrap();
    test_jr_misaligned();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
